branch_resolve_unit: RTL

Pipelined branch/jump resolution unit for the RV32I core, the successor to the single-cycle branch block. It accepts one control-transfer instruction per cycle under a valid/ready handshake and evaluates all six conditional branches plus JAL/JALR internally, with no external ALU. It maintains a 2-bit saturating branch history table (BHT) that fetch queries for predictions, and it reports redirects and mispredictions back to fetch.

---
 rtl/branch_resolve_if.sv | 63 ++++++
 rtl/branch_resolve_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_if.sv
// Handshake bundle between the issue pipeline and branch_resolve_unit.
// The master drives instructions and predict lookups; the slave resolves them.
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] program_counter;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            predicted_taken;
  logic            out_valid;
  logic            out_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] link_value;
  logic            mispredict;
  logic [1:0]      exception;
  logic [XLEN-1:0] predict_pc;
  logic            predict_taken;

  modport master (
    output flush,
    output in_valid,
    output instruction,
    output program_counter,
    output rs1_data,
    output rs2_data,
    output predicted_taken,
    output out_ready,
    output predict_pc,
    input  in_ready,
    input  out_valid,
    input  redirect,
    input  redirect_pc,
    input  link_value,
    input  mispredict,
    input  exception,
    input  predict_taken
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  instruction,
    input  program_counter,
    input  rs1_data,
    input  rs2_data,
    input  predicted_taken,
    input  out_ready,
    input  predict_pc,
    output in_ready,
    output out_valid,
    output redirect,
    output redirect_pc,
    output link_value,
    output mispredict,
    output exception,
    output predict_taken
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage RV32I branch/jump resolver with a 2-bit saturating BHT.
// Stage A latches and decodes; stage B compares, updates the BHT and drives results.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);

  localparam int IW = $clog2(BHT_DEPTH);

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ILL  = 2'b01;
  localparam logic [1:0] EXC_MIS  = 2'b10;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic [2:0]      f3;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic            pred;
    logic            is_br;
    logic            is_jal;
    logic            is_jalr;
  } stage_a_t;

  stage_a_t a_d;
  stage_a_t a_q;
  logic     a_valid;

  logic            out_valid;
  logic            redirect;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] link_value;
  logic [1:0]      exception;

  logic advance;
  logic in_ready;
  logic a_go;

  assign advance  = !out_valid || bus.out_ready;
  assign in_ready = !a_valid || advance;
  assign a_go     = a_valid && advance && !bus.flush;

  // ---------------- stage A: decode ----------------
  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3_in;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_i;
  logic        dec_br;
  logic        dec_jal;
  logic        dec_jalr;

  assign ins   = bus.instruction;
  assign opc   = ins[6:0];
  assign f3_in = ins[14:12];

  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};
  assign imm_i = {{20{ins[31]}}, ins[31:20]};

  // funct3 010/011 are the only holes in the branch space
  assign dec_br   = (opc == OP_BR) && (f3_in[2:1] != 2'b01);
  assign dec_jal  = (opc == OP_JAL);
  assign dec_jalr = (opc == OP_JALR) && (f3_in == 3'b000);

  always_comb begin
    a_d         = '0;
    a_d.f3      = f3_in;
    a_d.pc      = bus.program_counter;
    a_d.rs1     = bus.rs1_data;
    a_d.rs2     = bus.rs2_data;
    a_d.pred    = bus.predicted_taken;
    a_d.is_br   = dec_br;
    a_d.is_jal  = dec_jal;
    a_d.is_jalr = dec_jalr;
    unique case (1'b1)
      dec_br:  a_d.imm = XLEN'($signed(imm_b));
      dec_jal: a_d.imm = XLEN'($signed(imm_j));
      default: a_d.imm = XLEN'($signed(imm_i));
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else if (bus.flush) begin
      a_valid <= 1'b0;
    end else if (in_ready) begin
      a_valid <= bus.in_valid;
      if (bus.in_valid) a_q <= a_d;
    end
  end

  // ---------------- stage B: resolve ----------------
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic            taken;

  assign seq_pc   = a_q.pc + XLEN'(4);
  assign rel_tgt  = a_q.pc + a_q.imm;
  assign jalr_sum = a_q.rs1 + a_q.imm;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

  assign eq  = (a_q.rs1 == a_q.rs2);
  assign lt  = ($signed(a_q.rs1) < $signed(a_q.rs2));
  assign ltu = (a_q.rs1 < a_q.rs2);

  always_comb begin
    taken = 1'b0;
    case (a_q.f3)
      3'b000:  taken = eq;
      3'b001:  taken = !eq;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  logic [XLEN-1:0] b_npc;
  logic            b_redir;
  logic            b_mis;
  logic [1:0]      b_exc;
  logic            b_upd;

  // A misaligned target still reports the computed address in redirect_pc
  always_comb begin
    b_npc   = seq_pc;
    b_redir = 1'b0;
    b_mis   = 1'b0;
    b_exc   = EXC_ILL;
    b_upd   = 1'b0;
    unique case (1'b1)
      a_q.is_br: begin
        b_npc   = taken ? rel_tgt : seq_pc;
        b_upd   = 1'b1;
        b_exc   = b_npc[1] ? EXC_MIS : EXC_NONE;
        b_mis   = !b_npc[1] && (taken ^ a_q.pred);
        b_redir = b_mis;
      end
      a_q.is_jal: begin
        b_npc   = rel_tgt;
        b_exc   = b_npc[1] ? EXC_MIS : EXC_NONE;
        b_redir = !b_npc[1];
      end
      a_q.is_jalr: begin
        b_npc   = jalr_tgt;
        b_exc   = b_npc[1] ? EXC_MIS : EXC_NONE;
        b_redir = !b_npc[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      redirect    <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      link_value  <= '0;
      exception   <= EXC_NONE;
    end else if (bus.flush) begin
      out_valid  <= 1'b0;
      redirect   <= 1'b0;
      mispredict <= 1'b0;
    end else if (advance) begin
      out_valid  <= a_valid;
      redirect   <= a_valid && b_redir;
      mispredict <= a_valid && b_mis;
      if (a_valid) begin
        redirect_pc <= b_npc;
        link_value  <= seq_pc;
        exception   <= b_exc;
      end
    end
  end

  // ---------------- branch history table ----------------
  logic [1:0]    bht [BHT_DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_idx = a_q.pc[IW+1:2];
  assign rd_idx = bus.predict_pc[IW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (a_go && b_upd) begin
      if (taken && bht[wr_idx] != 2'b11)
        bht[wr_idx] <= bht[wr_idx] + 2'd1;
      else if (!taken && bht[wr_idx] != 2'b00)
        bht[wr_idx] <= bht[wr_idx] - 2'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.predict_pc[XLEN-1:IW+2],
                         bus.predict_pc[1:0], jalr_sum[0]};

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.redirect      = redirect;
  assign bus.mispredict    = mispredict;
  assign bus.redirect_pc   = redirect_pc;
  assign bus.link_value    = link_value;
  assign bus.exception     = exception;
  assign bus.predict_taken = bht[rd_idx][1];

endmodule
